// File: rtl/exibe_soma_7seg_if.sv
// Signal bundle between the adder-side driver and the sum display stage.
interface exibe_soma_7seg_if;
  logic [3:0] soma;
  logic       cout;
  logic       carrega;
  logic       ocupado;
  logic       pronto;
  logic [3:0] bcd_dez;
  logic [3:0] bcd_uni;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output soma, cout, carrega,
    input  ocupado, pronto, bcd_dez, bcd_uni, seg, an
  );

  modport slave (
    input  soma, cout, carrega,
    output ocupado, pronto, bcd_dez, bcd_uni, seg, an
  );
endinterface

// File: rtl/exibe_soma_7seg.sv
// Captures the 5-bit adder result, converts it to two BCD digits with a
// serial shift-add-3 engine and multiplexes them onto a 2-digit
// common-anode 7-segment display.
//
// state    | meaning
// ---------+----------------------------------------------------------
// OCIOSO   | idle, waiting for carrega; BCD outputs hold last result
// CONVERTE | one shift-add-3 step per clock, 5 steps, then back idle
module exibe_soma_7seg #(
  parameter int REFRESH_CYCLES = 1000
) (
  input logic               clk,
  input logic               rst_n,
  exibe_soma_7seg_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic {OCIOSO, CONVERTE} estado_t;

  estado_t     estado, prox_estado;
  logic [4:0]  v;
  logic [7:0]  scratch;
  logic [2:0]  passo;
  logic        pronto_r;
  logic [3:0]  dez_r, uni_r;
  logic        carregar, ultimo;
  logic [7:0]  ajustado;
  logic [12:0] deslocado;
  logic [CNT_W-1:0] cnt;
  logic        sel;

  function automatic logic [6:0] decodifica(input logic [3:0] d);
    case (d)
      4'd0:    decodifica = 7'b1000000;
      4'd1:    decodifica = 7'b1111001;
      4'd2:    decodifica = 7'b0100100;
      4'd3:    decodifica = 7'b0110000;
      4'd4:    decodifica = 7'b0011001;
      4'd5:    decodifica = 7'b0010010;
      4'd6:    decodifica = 7'b0000010;
      4'd7:    decodifica = 7'b1111000;
      4'd8:    decodifica = 7'b0000000;
      4'd9:    decodifica = 7'b0010000;
      default: decodifica = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step: add 3 to any nibble >= 5, then shift left.
  always_comb begin
    ajustado = scratch;
    if (scratch[3:0] >= 4'd5) ajustado[3:0] = scratch[3:0] + 4'd3;
    if (scratch[7:4] >= 4'd5) ajustado[7:4] = scratch[7:4] + 4'd3;
    deslocado = {ajustado, v} << 1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox_estado;
  end

  // Next-state and step control.
  always_comb begin
    prox_estado = estado;
    carregar    = 1'b0;
    ultimo      = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.carrega) begin
          carregar    = 1'b1;
          prox_estado = CONVERTE;
        end
      end
      CONVERTE: begin
        if (passo == 3'd4) begin
          ultimo      = 1'b1;
          prox_estado = OCIOSO;
        end
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  // Conversion datapath; results are only published on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v        <= '0;
      scratch  <= '0;
      passo    <= '0;
      pronto_r <= 1'b0;
      dez_r    <= '0;
      uni_r    <= '0;
    end else begin
      pronto_r <= ultimo;
      if (carregar) begin
        v       <= {bus.cout, bus.soma};
        scratch <= '0;
        passo   <= '0;
      end else if (estado == CONVERTE) begin
        v       <= deslocado[4:0];
        scratch <= deslocado[12:5];
        passo   <= passo + 3'd1;
      end
      if (ultimo) begin
        dez_r <= deslocado[12:9];
        uni_r <= deslocado[8:5];
      end
    end
  end

  // Free-running refresh counter; digit select flips on every wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      sel <= ~sel;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Display drive; tens digit is blanked when it is zero.
  always_comb begin
    bus.an  = 2'b10;
    bus.seg = decodifica(uni_r);
    if (sel) begin
      bus.an  = 2'b01;
      bus.seg = (dez_r == 4'd0) ? 7'b1111111 : decodifica(dez_r);
    end
  end

  assign bus.ocupado = (estado == CONVERTE);
  assign bus.pronto  = pronto_r;
  assign bus.bcd_dez = dez_r;
  assign bus.bcd_uni = uni_r;

endmodule

// File: tb/tb_exibe_soma_7seg.sv
// Directed bench for the sum display stage, built with a 4-cycle refresh.
module tb_exibe_soma_7seg;

  localparam int RC = 4;

  logic clk;
  logic rst_n;
  exibe_soma_7seg_if bus();

  exibe_soma_7seg #(.REFRESH_CYCLES(RC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       c;
    logic [3:0] s;
    int         dez;
    int         uni;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model of display phase and published digits
  int m_cnt = 0;
  int m_sel = 0;
  int m_dez = 0;
  int m_uni = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (m_cnt == RC - 1) begin
        m_cnt = 0;
        m_sel = 1 - m_sel;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sel = 0; m_dez = 0; m_uni = 0;
  endtask

  task automatic check_disp(input string nm);
    logic [6:0] es;
    logic [1:0] ea;
    if (m_sel == 0) begin
      ea = 2'b10; es = dec(m_uni);
    end else begin
      ea = 2'b01; es = (m_dez == 0) ? 7'b1111111 : dec(m_dez);
    end
    chk({nm, "_an"}, int'(bus.an), int'(ea));
    chk({nm, "_seg"}, int'(bus.seg), int'(es));
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_an"}, int'(bus.an), 2);
    chk({nm, "_seg"}, int'(bus.seg), 7'b1000000);
    chk({nm, "_dez"}, int'(bus.bcd_dez), 0);
    chk({nm, "_uni"}, int'(bus.bcd_uni), 0);
    chk({nm, "_ocupado"}, int'(bus.ocupado), 0);
    chk({nm, "_pronto"}, int'(bus.pronto), 0);
  endtask

  task automatic do_conv(input logic c, input logic [3:0] s, input int ed, input int eu,
                         input string nm);
    int busy;
    int n;
    bus.cout = c; bus.soma = s; bus.carrega = 1'b1;
    tick();
    bus.carrega = 1'b0;
    bus.soma = ~s; bus.cout = ~c;
    chk({nm, "_ocupado_rise"}, int'(bus.ocupado), 1);
    busy = 1; n = 0;
    while (bus.ocupado && n < 20) begin
      chk({nm, "_hold_dez"}, int'(bus.bcd_dez), m_dez);
      chk({nm, "_hold_uni"}, int'(bus.bcd_uni), m_uni);
      check_disp({nm, "_busy_disp"});
      tick();
      n++;
      if (bus.ocupado) busy++;
    end
    chk({nm, "_busy_cycles"}, busy, 5);
    chk({nm, "_pronto"}, int'(bus.pronto), 1);
    m_dez = ed; m_uni = eu;
    chk({nm, "_dez"}, int'(bus.bcd_dez), ed);
    chk({nm, "_uni"}, int'(bus.bcd_uni), eu);
    check_disp({nm, "_done_disp"});
    tick();
    chk({nm, "_pronto_fall"}, int'(bus.pronto), 0);
    check_disp({nm, "_after_disp"});
  endtask

  vec_t vecs[9];

  initial begin
    int np;
    int last;
    vecs[0] = '{1'b0, 4'd0,  0, 0};
    vecs[1] = '{1'b0, 4'd5,  0, 5};
    vecs[2] = '{1'b0, 4'd9,  0, 9};
    vecs[3] = '{1'b0, 4'd10, 1, 0};
    vecs[4] = '{1'b0, 4'd15, 1, 5};
    vecs[5] = '{1'b1, 4'd0,  1, 6};
    vecs[6] = '{1'b1, 4'd4,  2, 0};
    vecs[7] = '{1'b1, 4'd9,  2, 5};
    vecs[8] = '{1'b1, 4'd15, 3, 1};

    // reset with toggling inputs
    rst_n = 1'b0;
    bus.soma = 4'd0; bus.cout = 1'b0; bus.carrega = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.carrega = ~bus.carrega;
      bus.soma = bus.soma + 4'd7;
      bus.cout = ~bus.cout;
      tick();
      check_reset_vals("reset");
    end
    bus.carrega = 1'b0;
    model_reset();
    rst_n = 1'b1;
    // first switch to tens after RC edges
    for (int i = 0; i < RC + 2; i++) begin
      tick();
      check_disp("first_switch");
    end

    // maximum value first, then the whole table
    do_conv(1'b1, 4'hF, 3, 1, "max");
    for (int i = 0; i < 9; i++) begin
      do_conv(vecs[i].c, vecs[i].s, vecs[i].dez, vecs[i].uni, $sformatf("vec%0d", i));
      tick();
    end

    // leading-zero blank over several refresh periods
    do_conv(1'b0, 4'd9, 0, 9, "blank");
    for (int i = 0; i < 3 * RC; i++) begin
      tick();
      check_disp("blank_mux");
    end

    // load while busy: second request must be ignored
    bus.cout = 1'b1; bus.soma = 4'd0; bus.carrega = 1'b1;
    tick();
    bus.carrega = 1'b0;
    tick();
    tick();
    bus.soma = 4'd5; bus.carrega = 1'b1;
    tick();
    bus.carrega = 1'b0;
    np = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.pronto) begin
        np++;
        m_dez = 1; m_uni = 6;
      end
      check_disp("busy_load_disp");
    end
    chk("busy_load_pronto_count", np, 1);
    chk("busy_load_dez", int'(bus.bcd_dez), 1);
    chk("busy_load_uni", int'(bus.bcd_uni), 6);
    chk("busy_load_idle", int'(bus.ocupado), 0);

    // reset in the middle of a conversion
    bus.cout = 1'b1; bus.soma = 4'd4; bus.carrega = 1'b1;
    tick();
    bus.carrega = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("midrst");
    tick();
    check_reset_vals("midrst_hold");
    rst_n = 1'b1;
    tick();
    do_conv(1'b1, 4'd4, 2, 0, "after_rst");

    // back-to-back conversions with carrega held high
    bus.cout = 1'b1; bus.soma = 4'd9; bus.carrega = 1'b1;
    np = 0; last = -1;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bus.pronto) begin
        if (last >= 0) chk("b2b_interval", t - last, 6);
        last = t;
        np++;
        m_dez = 2; m_uni = 5;
      end
      check_disp("b2b_disp");
    end
    chk("b2b_pronto_count", np, 5);
    bus.carrega = 1'b0;
    for (int i = 0; i < 10 && bus.ocupado; i++) tick();
    chk("b2b_end_idle", int'(bus.ocupado), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
